// File: rtl/mano_seq_decoder_if.sv
// Handshake bundle between the bus/control side and the timing/decode front end.
// The master side drives run control and the bus word; the decoder answers with timing and decode.
interface mano_seq_decoder_if;
  logic        start;
  logic        hlt;
  logic        sc_clr;
  logic [15:0] ir_in;
  logic [7:0]  T;
  logic [7:0]  D;
  logic [15:0] B;
  logic        J;
  logic        run;

  modport master (
    output start, hlt, sc_clr, ir_in,
    input  T, D, B, J, run
  );

  modport slave (
    input  start, hlt, sc_clr, ir_in,
    output T, D, B, J, run
  );
endinterface

// File: rtl/mano_seq_decoder.sv
// Mano basic computer timing/decode front end: run flop S, sequence counter SC, IR, D/J latch.
// Registered state updates one clock after inputs; T and B are combinational from registers.
// No backpressure: every input is sampled on every rising edge.
module mano_seq_decoder (
  input  logic               clk,
  input  logic               rst,
  mano_seq_decoder_if.slave  bus
);

  logic        s_q, s_d;
  logic [2:0]  sc_q, sc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  d_q, d_d;
  logic        j_q, j_d;
  logic [7:0]  t;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= 1'b0;
      sc_q <= 3'd0;
      ir_q <= 16'h0000;
      d_q  <= 8'h00;
      j_q  <= 1'b0;
    end else begin
      s_q  <= s_d;
      sc_q <= sc_d;
      ir_q <= ir_d;
      d_q  <= d_d;
      j_q  <= j_d;
    end
  end

  always_comb begin
    s_d  = s_q;
    sc_d = sc_q;
    ir_d = ir_q;
    d_d  = d_q;
    j_d  = j_q;

    // hlt outranks both start and sc_clr; SC is pinned to 0 whenever S is low.
    if (bus.hlt) begin
      s_d  = 1'b0;
      sc_d = 3'd0;
    end else if (!s_q) begin
      s_d  = bus.start;
      sc_d = 3'd0;
    end else if (bus.sc_clr) begin
      sc_d = 3'd0;
    end else begin
      sc_d = sc_q + 3'd1;
    end

    if (t[1]) begin
      ir_d = bus.ir_in;
    end

    if (t[2]) begin
      d_d = 8'd1 << ir_q[14:12];
      j_d = ir_q[15];
    end
  end

  always_comb begin
    t       = s_q ? (8'd1 << sc_q) : 8'h00;
    bus.T   = t;
    bus.D   = d_q;
    bus.B   = ir_q;
    bus.J   = j_q;
    bus.run = s_q;
  end

endmodule

// File: doc/mano_seq_decoder.md
# mano_seq_decoder

Timing and instruction-decode front end for the Mano basic computer. It holds the run flip-flop S and the 3-bit sequence counter SC, latches the instruction register, and produces the signals that the accumulator/control decode logic consumes:
- one-hot timing `T[7:0]`
- decoded opcode `D[7:0]`
- instruction bits `B[15:0]`
- indirect flag `J`

It sits between the memory/bus path and the combinational control-signal decoders.

## Interface
Parameters: none; all widths are fixed by the Mano ISA.

- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: sets run flip-flop S.
- `hlt` in 1: clears S (HLT execution).
- `sc_clr` in 1: clears SC to 0 at end of instruction.
- `ir_in` in 16: instruction word from common bus.
- `T` out 8: one-hot timing, `T[i]` = (SC==i) & S; all zero when halted.
- `D` out 8: registered one-hot decode of `IR[14:12]`.
- `B` out 16: `B[i]` = `IR[i]`.
- `J` out 1: registered `IR[15]` (I flip-flop).
- `run` out 1: current S.

## Operation
Reset (`rst`=1 at an edge) forces S=0, SC=0, IR=16'h0000, D=8'h00, J=0. Consequently `T`=8'h00, `B`=16'h0000, `run`=0. Reset overrides every other input.

Run control, evaluated each edge in priority order:
- `hlt`=1: S<=0 and SC<=0. This wins over `start` and `sc_clr`.
- `start`=1 with S=0: S<=1, SC stays 0.
- `start` while S=1: ignored.

Sequence counter, when S=1 and `hlt`=0:
- `sc_clr`=1: SC<=0.
- Otherwise: SC<=SC+1, 3-bit, wraps 7->0.
- When S=0, SC holds at 0.

Instruction register:
- IR<=`ir_in` on an edge where `T[1]`=1 (fetch T1).
- IR holds at all other times, including while halted.

Decode latch:
- On an edge where `T[2]`=1: D<=one-hot(`IR[14:12]`) and J<=`IR[15]`.
- D and J hold until the next T2 edge.
- D never has more than one bit set. The only all-zero state is post-reset.

`T` is decoded combinationally from registered SC and S. It is glitch-free relative to `clk` and always has at most one bit set.

## Timing
- `start` sampled at edge n: `T[0]` is high in cycle n+1, `T[1]` in n+2, `T[2]` in n+3.
- IR is loaded at the T1 edge and valid during T2. D and J are valid from T3 onward, so `D[7]&~J&T[3]` and `D[k]&T[5]` see stable values.
- `sc_clr` asserted during Tk: `T[0]` is high in the next cycle, with no idle cycle between instructions.
- `hlt` asserted during Tk: `T`=0 from the next cycle. S stays 0 until a later `start`, and the restart begins at T0.
- `hlt`, `sc_clr` and `start` all high in the same cycle: result is S=0, SC=0.
- SC reaching T7 with no `sc_clr`: the next cycle is T0. This is legal for memory-reference instructions that end at T6/T7.
- `rst` mid-instruction (any Tk): all outputs take their reset values in the next cycle. The partially decoded instruction is discarded.
- Latency from an input change to a registered output is exactly one clock. `B` follows IR with zero added latency.

## Test plan
1. **Reset then idle.** Stimulus: `rst` 2 cycles, then 5 cycles idle. Required response: `T`=0, `D`=0, `B`=0, `J`=0, `run`=0 throughout.
2. **Register-reference fetch (CMA).** Stimulus: `start` pulse, `ir_in`=16'h7200 held; `sc_clr` during T3. Required response:
   - T sequence 01,02,04,08,01.
   - `B`=16'h7200 from T2.
   - `D`=8'h80 and `J`=0 from T3.
3. **Indirect AND.** Stimulus: `ir_in`=16'h8123 at T1; `sc_clr` at T5. Required response:
   - `D`=8'h01 and `J`=1 from T3.
   - T reaches 8'h20, then returns to 8'h01.
4. **SC wrap.** Stimulus: `start`, `ir_in`=16'h2000, no `sc_clr` for 9 cycles. Required response:
   - T steps 01..80, then 01.
   - IR reloads at the second T1.
   - D re-latches 8'h04 at the second T2.
5. **Halt priority.** Stimulus: during T3, assert `hlt`, `sc_clr` and `start` together. Required response:
   - `T`=0 and `run`=0 next cycle, and they remain so.
   - A later lone `start` gives `T`=8'h01 the following cycle.
6. **Reset mid-instruction.** Stimulus: `rst` during T4 of an ADD (`ir_in`=16'h1050). Required response: next cycle `T`=0, `D`=0, `B`=0, `J`=0, `run`=0.
